pf_lanectrl_pause_ctrl: RTL and testbench



---
 rtl/pf_lanectrl_pause_pkg.sv | 23 ++
 rtl/pf_lanectrl_pause_ctrl_lane.sv | 166 ++++++++++++++++
 rtl/pf_lanectrl_pause_ctrl.sv | 84 ++++++++
 tb/tb_pf_lanectrl_pause_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pf_lanectrl_pause_pkg.sv
// -----------------------------------------------------------------------------
// pf_lanectrl_pause_pkg
// Shared types and constants for the multi-lane HS_IO_CLK_PAUSE conditioner.
//   PAUSE_CNT_W  : width of the per-lane pause/gap counter
//   lane_state_e : per-lane FSM state (IDLE / ASSERT / HOLD / GAP)
//   is_pausing() : decode of the states during which the lane output is high
// -----------------------------------------------------------------------------
package pf_lanectrl_pause_pkg;

    localparam int PAUSE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2,
        ST_GAP    = 2'd3
    } lane_state_e;

    function automatic logic is_pausing(input lane_state_e st);
        return (st == ST_ASSERT) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/pf_lanectrl_pause_ctrl_lane.sv
// -----------------------------------------------------------------------------
// pf_lanectrl_pause_lane
// One pause lane: synchroniser, min-width / min-gap FSM, counter, pending bit
// and the registered pause output.
// Optional feature: PF_LANECTRL_PAUSE_NEGEDGE_EN clocks the output flop on the
// falling edge of clk (half a cycle earlier, same widths).
// Ports:
//   clk         in   sole clock
//   rst         in   asynchronous active-high reset
//   pause_raw   in   raw pause request, asynchronous to clk
//   pause_sync  out  conditioned pause, registered
//   busy        out  lane FSM is not IDLE (combinational, registered by top)
//   stretch_det out  a request dropped before the minimum width (combinational)
// -----------------------------------------------------------------------------
module pf_lanectrl_pause_lane
    import pf_lanectrl_pause_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PAUSE   = 2,
    parameter int MIN_GAP     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pause_raw,
    output logic pause_sync,
    output logic busy,
    output logic stretch_det
);

    localparam logic [PAUSE_CNT_W-1:0] CNT_ONE     = PAUSE_CNT_W'(1);
    localparam logic [PAUSE_CNT_W-1:0] MIN_PAUSE_C = PAUSE_CNT_W'(MIN_PAUSE);
    localparam logic [PAUSE_CNT_W-1:0] MIN_GAP_C   = PAUSE_CNT_W'(MIN_GAP);

    // ---------------------------------------------------------------------
    // Synchroniser. The first flop is the metastability catcher and carries
    // the sync/keep attributes so tools keep it intact and place it tightly.
    // ---------------------------------------------------------------------
    (* async_reg = "true", keep = "true" *) logic sync_meta_q;
    logic s;

    // NOTE: every flop uses non-blocking assignment so all registers update
    // from the same pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_meta_q <= 1'b0;
        else     sync_meta_q <= pause_raw;
    end

    generate
        if (SYNC_STAGES == 1) begin : g_sync_one
            assign s = sync_meta_q;
        end else begin : g_sync_tail
            logic [SYNC_STAGES-2:0] tail_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tail_q <= '0;
                end else begin
                    tail_q[0] <= sync_meta_q;
                    for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                        tail_q[i] <= tail_q[i-1];
                    end
                end
            end
            assign s = tail_q[SYNC_STAGES-2];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // FSM, counter and pending bit
    // ---------------------------------------------------------------------
    lane_state_e            state_q, state_d;
    logic [PAUSE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   pending_q, pending_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        stretch_det = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_ASSERT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == MIN_PAUSE_C) begin
                    if (s) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    // Request already gone but the pulse is still short:
                    // the lane is stretching it.
                    if (!s) stretch_det = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!s) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_GAP: begin
                // Remember a request arriving during the gap so it is
                // replayed once the minimum low time has elapsed.
                if (s) pending_d = 1'b1;
                if (cnt_q == MIN_GAP_C) begin
                    if (pending_q || s) begin
                        state_d   = ST_ASSERT;
                        cnt_d     = CNT_ONE;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // ---------------------------------------------------------------------
    // Output flop: registered decode of the pausing states
    // ---------------------------------------------------------------------
    logic pause_sync_q, pause_sync_d;

    always_comb begin
        pause_sync_d = is_pausing(state_q);
    end

`ifdef PF_LANECTRL_PAUSE_NEGEDGE_EN
    always_ff @(negedge clk or posedge rst) begin
        if (rst) pause_sync_q <= 1'b0;
        else     pause_sync_q <= pause_sync_d;
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pause_sync_q <= 1'b0;
        else     pause_sync_q <= pause_sync_d;
    end
`endif

    assign pause_sync = pause_sync_q;

endmodule

// File: rtl/pf_lanectrl_pause_ctrl.sv
// -----------------------------------------------------------------------------
// pf_lanectrl_pause_ctrl
// Multi-lane HS_IO_CLK_PAUSE conditioner: per-lane synchronisation with
// minimum pause width and minimum inter-pause gap, sticky stretch flags and
// an aggregate busy flag.
// Optional feature: PF_LANECTRL_PAUSE_NEGEDGE_EN (falling-edge output flops,
// see pf_lanectrl_pause_lane). Flags and busy are always rising-edge.
// Ports:
//   CLK                   in   sole clock
//   RESET                 in   asynchronous active-high reset
//   HS_IO_CLK_PAUSE       in   [LANES] raw pause requests, asynchronous
//   STATUS_CLR            in   synchronous clear of PAUSE_STRETCHED
//   HS_IO_CLK_PAUSE_SYNC  out  [LANES] conditioned pause per lane
//   PAUSE_STRETCHED       out  [LANES] sticky: lane extended a short request
//   PAUSE_BUSY            out  registered OR of all lanes not IDLE
// -----------------------------------------------------------------------------
module pf_lanectrl_pause_ctrl
    import pf_lanectrl_pause_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PAUSE   = 2,
    parameter int MIN_GAP     = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [LANES-1:0] HS_IO_CLK_PAUSE,
    input  logic             STATUS_CLR,
    output logic [LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
    output logic [LANES-1:0] PAUSE_STRETCHED,
    output logic             PAUSE_BUSY
);

    generate
        if (LANES < 1 || LANES > 16 || SYNC_STAGES < 1 || SYNC_STAGES > 4 ||
            MIN_PAUSE < 1 || MIN_PAUSE > 15 || MIN_GAP < 1 || MIN_GAP > 15)
        begin : g_bad_param
            $fatal(1, "pf_lanectrl_pause_ctrl: parameter out of range");
        end
    endgenerate

    logic [LANES-1:0] lane_busy;
    logic [LANES-1:0] lane_stretch;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            pf_lanectrl_pause_lane #(
                .SYNC_STAGES (SYNC_STAGES),
                .MIN_PAUSE   (MIN_PAUSE),
                .MIN_GAP     (MIN_GAP)
            ) u_lane (
                .clk         (CLK),
                .rst         (RESET),
                .pause_raw   (HS_IO_CLK_PAUSE[l]),
                .pause_sync  (HS_IO_CLK_PAUSE_SYNC[l]),
                .busy        (lane_busy[l]),
                .stretch_det (lane_stretch[l])
            );
        end
    endgenerate

    logic [LANES-1:0] stretched_q, stretched_d;
    logic             busy_q, busy_d;

    always_comb begin
        // Set is OR-ed after the clear so a new stretch in the clear cycle wins.
        stretched_d = (stretched_q & ~{LANES{STATUS_CLR}}) | lane_stretch;
        busy_d      = |lane_busy;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stretched_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            stretched_q <= stretched_d;
            busy_q      <= busy_d;
        end
    end

    assign PAUSE_STRETCHED = stretched_q;
    assign PAUSE_BUSY      = busy_q;

endmodule

// File: tb/tb_pf_lanectrl_pause_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pf_lanectrl_pause_ctrl
// Directed bench for pf_lanectrl_pause_ctrl with LANES=2, SYNC_STAGES=2,
// MIN_PAUSE=3, MIN_GAP=2. Vector n is driven before rising edge n and its
// expected outputs are checked 1 time unit after that edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pf_lanectrl_pause_ctrl;

    localparam int LANES = 2;
    localparam int NVEC  = 37;

    logic             clk;
    logic             rst;
    logic [LANES-1:0] pause_in;
    logic             status_clr;
    logic [LANES-1:0] pause_sync;
    logic [LANES-1:0] stretched;
    logic             busy;

    int n_vec;
    int n_fail;

    pf_lanectrl_pause_ctrl #(
        .LANES       (LANES),
        .SYNC_STAGES (2),
        .MIN_PAUSE   (3),
        .MIN_GAP     (2)
    ) dut (
        .CLK                  (clk),
        .RESET                (rst),
        .HS_IO_CLK_PAUSE      (pause_in),
        .STATUS_CLR           (status_clr),
        .HS_IO_CLK_PAUSE_SYNC (pause_sync),
        .PAUSE_STRETCHED      (stretched),
        .PAUSE_BUSY           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] raw;
        logic       clr;
        logic [1:0] exp_sync;
        logic [1:0] exp_st;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] raw, input logic clr);
        pause_in   = raw;
        status_clr = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] raw, input logic [1:0] s,
                                input logic [1:0] st, input logic b);
        vec_t v;
        v.raw      = raw;
        v.clr      = 1'b0;
        v.exp_sync = s;
        v.exp_st   = st;
        v.exp_busy = b;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] exp_a;
        n_vec  = 0;
        n_fail = 0;

        // Scenario 2: 1-cycle request on lane 0 sampled at edge 10.
        for (int i = 0; i <= 12; i++) tbl[i] = mk(2'b00, 2'b00, 2'b00, 1'b0);
        tbl[10] = mk(2'b01, 2'b00, 2'b00, 1'b0);
        for (int i = 13; i <= 15; i++) tbl[i] = mk(2'b00, 2'b01, 2'b01, 1'b1);
        for (int i = 16; i <= 17; i++) tbl[i] = mk(2'b00, 2'b00, 2'b01, 1'b1);
        for (int i = 18; i <= 19; i++) tbl[i] = mk(2'b00, 2'b00, 2'b01, 1'b0);
        // Scenario 3: lane 1 held for edges 20..29 -> 10-cycle pulse 23..32.
        for (int i = 20; i <= 22; i++) tbl[i] = mk(2'b10, 2'b00, 2'b01, 1'b0);
        for (int i = 23; i <= 29; i++) tbl[i] = mk(2'b10, 2'b10, 2'b01, 1'b1);
        for (int i = 30; i <= 32; i++) tbl[i] = mk(2'b00, 2'b10, 2'b01, 1'b1);
        for (int i = 33; i <= 34; i++) tbl[i] = mk(2'b00, 2'b00, 2'b01, 1'b1);
        for (int i = 35; i <= 36; i++) tbl[i] = mk(2'b00, 2'b00, 2'b01, 1'b0);

        // Reset held with toggling inputs: everything stays low.
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(2'(i + 1), 1'(i));
            check("reset_hold", {3'b0, pause_sync, stretched, busy}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].raw, tbl[i].clr);
            check($sformatf("vec%0d", i), {3'b0, pause_sync, stretched, busy},
                  {3'b0, tbl[i].exp_sync, tbl[i].exp_st, tbl[i].exp_busy});
        end

        // Held request released, re-asserted one cycle later for one cycle:
        // 5-cycle pulse, exactly 2 cycles low, then a 3-cycle pulse.
        exp_a = 17'b0_0001_1100_1111_1000;
        for (int i = 0; i < 17; i++) begin
            if (i <= 4 || i == 6) step(2'b01, 1'b0);
            else                  step(2'b00, 1'b0);
            check($sformatf("regap%0d", i), {6'b0, pause_sync}, {6'b0, 1'b0, exp_a[i]});
        end

        // STATUS_CLR colliding with a new stretch on lane 1.
        step(2'b10, 1'b0);
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);
        check("stretch_pre", {6'b0, stretched}, 8'h01);
        step(2'b00, 1'b1);
        check("clr_vs_set", {6'b0, stretched}, 8'h02);
        check("clr_pulse", {6'b0, pause_sync}, 8'h02);
        for (int i = 0; i < 6; i++) step(2'b00, 1'b0);
        check("sticky", {6'b0, stretched}, 8'h02);
        step(2'b00, 1'b1);
        check("clr_alone", {6'b0, stretched}, 8'h00);

        // RESET in HOLD drops outputs immediately; held request restarts.
        for (int i = 0; i < 8; i++) step(2'b01, 1'b0);
        check("hold_pre", {5'b0, pause_sync, busy}, 8'h03);
        #2 rst = 1'b1;
        #1;
        check("rst_async", {3'b0, pause_sync, stretched, busy}, 8'h00);
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        check("rst_held", {3'b0, pause_sync, stretched, busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 1'b0);
            check($sformatf("restart%0d", i), {6'b0, pause_sync}, 8'h00);
        end
        @(negedge clk);
        #1;
`ifdef PF_LANECTRL_PAUSE_NEGEDGE_EN
        check("restart_half", {6'b0, pause_sync}, 8'h01);
`else
        check("restart_half", {6'b0, pause_sync}, 8'h00);
`endif
        step(2'b01, 1'b0);
        check("restart3", {5'b0, pause_sync, busy}, 8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
